mode_scheduler: RTL and testbench

MODE_SCHEDULER -- requirements
Module: mode_scheduler

---
 rtl/mode_scheduler.sv | 145 ++++++++++++++
 tb/tb_mode_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mode_scheduler.sv
// Mode/LED scheduler: debounced buttons, auto dwell cycling,
// and a timed blanking window on every mode change.
module mode_scheduler #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DWELL_CYCLES    = 50000000,
  parameter int BLANK_CYCLES    = 1000,
  parameter int LED_COUNT       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_led,
  input  logic       auto_en,
  output logic [3:0] mode_select,
  output logic [3:0] led_select,
  output logic       blank,
  output logic       mode_changed
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DW_W = $clog2(DWELL_CYCLES + 1);
  localparam int BL_W = $clog2(BLANK_CYCLES + 1);

  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW_W-1:0] DW_MAX  = DW_W'(DWELL_CYCLES - 1);
  localparam logic [BL_W-1:0] BL_LOAD = BL_W'(BLANK_CYCLES - 1);
  localparam logic [3:0]      LED_MAX = 4'(LED_COUNT - 1);

  typedef enum logic {
    RUN   = 1'b0,
    BLANK = 1'b1
  } state_t;

  // bit 0 = mode button, bit 1 = LED button
  logic [1:0]      btn;
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      deb;
  logic [1:0]      press;
  logic [DB_W-1:0] dcnt [2];

  state_t          state;
  state_t          state_nx;
  logic [DW_W-1:0] dwell;
  logic [BL_W-1:0] bcnt;
  logic            dwell_exp;
  logic            mode_req;
  logic            advance;

  assign btn = {btn_led, btn_mode};

  // Two-flop synchronizers for the asynchronous buttons
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Debounce: accept a new level after enough consecutive samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb     <= '0;
      press   <= '0;
      dcnt[0] <= '0;
      dcnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DB_MAX) begin
          deb[i]   <= sync2[i];
          dcnt[i]  <= '0;
          press[i] <= sync2[i];
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
      end
    end
  end

  assign dwell_exp = auto_en && (dwell == DW_MAX);
  assign mode_req  = press[0] || dwell_exp;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      RUN:   if (mode_req) state_nx = BLANK;
      BLANK: if (bcnt == '0) state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    blank   = (state == BLANK);
    advance = (state == RUN) && mode_req;
  end

  // Mode, blank timer and dwell timer datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_select  <= '0;
      mode_changed <= 1'b0;
      bcnt         <= '0;
      dwell        <= '0;
    end else begin
      mode_changed <= advance;
      if (advance) begin
        mode_select <= {2'b00, mode_select[1:0] + 2'd1};
      end
      if (advance) begin
        bcnt <= BL_LOAD;
      end else if (blank && bcnt != '0) begin
        bcnt <= bcnt - 1'b1;
      end
      if (advance || !auto_en) begin
        dwell <= '0;
      end else if (state == RUN) begin
        dwell <= dwell + 1'b1;
      end
    end
  end

  // LED index steps on every LED press, independent of blanking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_select <= '0;
    end else if (press[1]) begin
      led_select <= (led_select == LED_MAX) ? 4'd0 : led_select + 4'd1;
    end
  end

endmodule

// File: tb/tb_mode_scheduler.sv
// Bench for mode_scheduler: behavioural model plus directed
// and randomized stimulus, compared every cycle.
module tb_mode_scheduler;

  localparam int D  = 3;
  localparam int DW = 20;
  localparam int B  = 4;
  localparam int LC = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_led = 1'b0;
  logic       auto_en = 1'b0;
  logic [3:0] mode_select;
  logic [3:0] led_select;
  logic       blank;
  logic       mode_changed;

  int n_checks = 0;
  int n_fail = 0;

  int mc_t[$];
  int mc_m[$];

  // behavioural model state
  bit hist_m [2][8];
  bit deb_m  [2];
  bit pend_m [2];
  int m_mode;
  int m_led;
  int m_left;
  int m_dwell;
  bit m_mc;

  mode_scheduler #(
    .DEBOUNCE_CYCLES(D),
    .DWELL_CYCLES   (DW),
    .BLANK_CYCLES   (B),
    .LED_COUNT      (LC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_mode    (btn_mode),
    .btn_led     (btn_led),
    .auto_en     (auto_en),
    .mode_select (mode_select),
    .led_select  (led_select),
    .blank       (blank),
    .mode_changed(mode_changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at cycle %0d",
               name, act, exp, int'($time / 10));
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      deb_m[i]  = 1'b0;
      pend_m[i] = 1'b0;
      for (int j = 0; j < 8; j++) hist_m[i][j] = 1'b0;
    end
    m_mode  = 0;
    m_led   = 0;
    m_left  = 0;
    m_dwell = 0;
    m_mc    = 1'b0;
  endtask

  // One clock of the model: button levels accepted once the
  // last D synchronized samples all disagree with the current level.
  task automatic model_step();
    bit raw [2];
    bit use_p [2];
    bit settled;
    bit req;
    raw[0] = btn_mode;
    raw[1] = btn_led;
    for (int i = 0; i < 2; i++) begin
      use_p[i]  = pend_m[i];
      pend_m[i] = 1'b0;
      for (int j = 7; j > 0; j--) hist_m[i][j] = hist_m[i][j-1];
      hist_m[i][0] = raw[i];
      settled = 1'b1;
      for (int j = 2; j < D + 2; j++)
        if (hist_m[i][j] == deb_m[i]) settled = 1'b0;
      if (settled) begin
        deb_m[i]  = !deb_m[i];
        pend_m[i] = deb_m[i];
      end
    end
    m_mc = 1'b0;
    if (m_left == 0) begin
      req = use_p[0] || (auto_en && m_dwell == DW - 1);
      if (req) begin
        m_mode  = (m_mode + 1) % 4;
        m_mc    = 1'b1;
        m_left  = B;
        m_dwell = 0;
      end else begin
        m_dwell = auto_en ? m_dwell + 1 : 0;
      end
    end else begin
      m_left  = m_left - 1;
      m_dwell = 0;
    end
    if (use_p[1]) m_led = (m_led + 1) % LC;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Every-cycle comparison against the model, plus pulse log
  initial begin
    forever begin
      @(negedge clk);
      check("mode_select", mode_select, m_mode);
      check("led_select", led_select, m_led);
      check("blank", blank, (m_left > 0) ? 1 : 0);
      check("mode_changed", mode_changed, m_mc);
      if (mode_changed) begin
        mc_t.push_back(int'($time / 10));
        mc_m.push_back(int'(mode_select));
      end
    end
  end

  task automatic goto(input int c);
    while (int'($time / 10) < c) @(negedge clk);
  endtask

  task automatic wait_mc(output int at);
    at = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (mode_changed) begin
        at = int'($time / 10);
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_mc: got no pulse, expected one within 100 cycles");
  endtask

  initial begin
    int t;
    int t0;
    int tc;
    int ta;
    int j;
    int pulses;
    int blanks;
    int exp_modes [3];
    int exp_t [3];
    int exp_m [3];
    exp_modes = '{3, 0, 1};
    exp_t     = '{24, 48, 72};
    exp_m     = '{2, 3, 0};

    // reset held with toggling buttons
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      btn_mode = 1'($urandom);
      btn_led  = 1'($urandom);
    end
    check("rst_mode", mode_select, 0);
    check("rst_led", led_select, 0);
    check("rst_blank", blank, 0);
    check("rst_mc", mode_changed, 0);
    btn_mode = 1'b0;
    btn_led  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_mode", mode_select, 0);
    check("idle_led", led_select, 0);
    check("idle_blank", blank, 0);

    // glitch shorter than the debounce window
    btn_mode = 1'b1;
    repeat (2) @(negedge clk);
    btn_mode = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch_mode", mode_select, 0);

    // genuine press held 10 cycles
    btn_mode = 1'b1;
    pulses = 0;
    blanks = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 9) btn_mode = 1'b0;
      pulses += int'(mode_changed);
      blanks += int'(blank);
    end
    check("press_mode", mode_select, 1);
    check("press_pulses", pulses, 1);
    check("press_blank_len", blanks, 4);
    repeat (10) @(negedge clk);

    // automatic cycling
    auto_en = 1'b1;
    tc = int'($time / 10);
    wait_mc(t);
    check("auto_first", t - tc, DW);
    check("auto_mode0", mode_select, 2);
    t0 = t;
    for (int i = 0; i < 3; i++) begin
      wait_mc(t);
      check("auto_interval", t - t0, DW + B);
      check("auto_mode", mode_select, exp_modes[i]);
      t0 = t;
    end

    // press on the dwell-expiry edge, then a press inside BLANK
    ta = t0;
    goto(ta + 18);
    btn_mode = 1'b1;
    goto(ta + 26);
    btn_mode = 1'b0;
    goto(ta + 44);
    btn_mode = 1'b1;
    goto(ta + 52);
    btn_mode = 1'b0;
    goto(ta + 80);
    j = 0;
    foreach (mc_t[k]) begin
      if (mc_t[k] > ta && mc_t[k] <= ta + 80) begin
        if (j < 3) begin
          check("coll_time", mc_t[k] - ta, exp_t[j]);
          check("coll_mode", mc_m[k], exp_m[j]);
        end
        j++;
      end
    end
    check("coll_count", j, 3);

    // LED presses alternating between RUN and BLANK
    for (int i = 0; i < 9; i++) begin
      wait_mc(t);
      if (i % 2 == 1) begin
        goto(t + 19);
        btn_led = 1'b1;
        goto(t + 25);
      end else begin
        goto(t + 6);
        btn_led = 1'b1;
        goto(t + 12);
      end
      btn_led = 1'b0;
      goto(t + 30);
      check("led_step", led_select, (i + 1) % LC);
    end

    // randomized stimulus
    for (int i = 0; i < 200; i++) begin
      btn_mode = 1'($urandom);
      btn_led  = 1'($urandom);
      if ($urandom_range(0, 7) == 0) auto_en = ~auto_en;
      repeat ($urandom_range(1, 12)) @(negedge clk);
    end

    // reset during the second BLANK cycle
    auto_en  = 1'b0;
    btn_mode = 1'b0;
    btn_led  = 1'b0;
    repeat (20) @(negedge clk);
    btn_mode = 1'b1;
    wait_mc(t);
    @(posedge clk);
    #2;
    check("mid_pre_blank", blank, 1);
    rst_n = 1'b0;
    #1;
    check("mid_blank", blank, 0);
    check("mid_mode", mode_select, 0);
    check("mid_mc", mode_changed, 0);
    btn_mode = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_mode", mode_select, 0);
    check("post_led", led_select, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
